// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit 7-segment driver: FSM states,
// active-high segment patterns {g..a}, decoder codes and the double-dabble step.
package seg7_pkg;

  typedef enum logic [0:0] {IDLE, CONVERT} state_e;

  localparam int unsigned ConvSteps = 7;

  localparam logic [3:0] CodeDash  = 4'd10;
  localparam logic [3:0] CodeBlank = 4'd11;

  localparam logic [6:0] Seg0     = 7'b0111111;
  localparam logic [6:0] Seg1     = 7'b0000110;
  localparam logic [6:0] Seg2     = 7'b1011011;
  localparam logic [6:0] Seg3     = 7'b1001111;
  localparam logic [6:0] Seg4     = 7'b1100110;
  localparam logic [6:0] Seg5     = 7'b1101101;
  localparam logic [6:0] Seg6     = 7'b1111101;
  localparam logic [6:0] Seg7     = 7'b0000111;
  localparam logic [6:0] Seg8     = 7'b1111111;
  localparam logic [6:0] Seg9     = 7'b1101111;
  localparam logic [6:0] SegDash  = 7'b1000000;
  localparam logic [6:0] SegBlank = 7'b0000000;

  // One shift-add-3 step on {bcd[7:0], bin[6:0]}.
  function automatic logic [14:0] dabble_step(input logic [14:0] sr);
    logic [14:0] adj;
    adj = sr;
    if (adj[14:11] >= 4'd5) adj[14:11] = adj[14:11] + 4'd3;
    if (adj[10:7] >= 4'd5) adj[10:7] = adj[10:7] + 4'd3;
    return {adj[13:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-high {g..a} pattern; 10 = dash, 11 = blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SegBlank;
    case (code)
      4'd0:      pattern = Seg0;
      4'd1:      pattern = Seg1;
      4'd2:      pattern = Seg2;
      4'd3:      pattern = Seg3;
      4'd4:      pattern = Seg4;
      4'd5:      pattern = Seg5;
      4'd6:      pattern = Seg6;
      4'd7:      pattern = Seg7;
      4'd8:      pattern = Seg8;
      4'd9:      pattern = Seg9;
      CodeDash:  pattern = SegDash;
      default:   pattern = SegBlank;
    endcase
  end

endmodule

// File: rtl/seg7_display_2dig.sv
// Two-digit multiplexed 7-segment driver with sequential binary-to-BCD conversion.
// Define SEG7_BLANK_LZ_EN to blank a leading-zero tens digit.
module seg7_display_2dig
  import seg7_pkg::*;
#(
  parameter int unsigned TICKS_PER_DIGIT = 50000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clkIn,
  input  logic       rst,
  input  logic [6:0] value,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       busy,
  output logic       ovf
);

  localparam int unsigned TickW   = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [6:0]  SegOff  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]  AnOff   = ACTIVE_LOW ? 2'b11 : 2'b00;

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [6:0]        cap_q, cap_d;
  logic [14:0]       sr_q, sr_d, sr_step;
  logic [2:0]        iter_q, iter_d;
  logic [3:0]        tens_q, tens_d, ones_q, ones_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic              sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;
  logic [1:0]        an_q, an_d;
  logic [3:0]        tens_code, digit_code;
  logic [6:0]        pattern;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cap_d     = cap_q;
    sr_d      = sr_q;
    iter_d    = iter_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    sr_step   = dabble_step(sr_q);
    case (state_q)
      IDLE: begin
        if (pending_q || (value != cap_q)) begin
          cap_d     = value;
          sr_d      = {8'd0, value};
          pending_d = 1'b0;
          iter_d    = 3'd0;
          busy_d    = 1'b1;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        sr_d   = sr_step;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'(ConvSteps - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          // Tens nibble may overflow above 99; those values show dashes anyway.
          if (cap_q > 7'd99) begin
            tens_d = CodeDash;
            ones_d = CodeDash;
            ovf_d  = 1'b1;
          end else begin
            tens_d = sr_step[14:11];
            ones_d = sr_step[10:7];
            ovf_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SEG7_BLANK_LZ_EN
  assign tens_code = ((tens_q == 4'd0) && !ovf_q) ? CodeBlank : tens_q;
`else
  assign tens_code = tens_q;
`endif

  assign digit_code = sel_q ? tens_code : ones_q;

  seg7_decode u_decode (
    .code    (digit_code),
    .pattern (pattern)
  );

  // Scan runs freely; conversions never disturb tick or sel.
  always_comb begin
    if (tick_q == TickW'(TICKS_PER_DIGIT - 1)) begin
      tick_d = '0;
      sel_d  = ~sel_q;
    end else begin
      tick_d = tick_q + 1'b1;
      sel_d  = sel_q;
    end
    seg_d = ACTIVE_LOW ? ~pattern : pattern;
    an_d  = sel_q ? 2'b10 : 2'b01;
    if (ACTIVE_LOW) an_d = ~an_d;
  end

  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b1;
      cap_q     <= 7'd0;
      sr_q      <= 15'd0;
      iter_q    <= 3'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      tick_q    <= '0;
      sel_q     <= 1'b0;
      seg_q     <= SegOff;
      an_q      <= AnOff;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cap_q     <= cap_d;
      sr_q      <= sr_d;
      iter_q    <= iter_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule
